// File: rtl/umich_pkg.sv
// Shared types and helpers for the round-robin select stage.
// Holds the output state enum, pointer width helper and one-hot encoder.
package umich_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int MAX_N = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(
    input int idx,
    input int n
  );
    return (idx >= 0 && idx < n) ? (MAX_N'(1) << idx) : '0;
  endfunction

endpackage

// File: rtl/umich_rr_pick.sv
// Combinational rotating-priority picker.
// Scans req from ptr upward with wrap; out-of-range ptr codes act as 0.
module umich_rr_pick
  import umich_pkg::*;
#(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win,
  output logic             any
);

  localparam logic [PTR_W:0] NV = (PTR_W+1)'(N);

  logic [PTR_W-1:0] w_p;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [PTR_W-1:0] w_pos [N+1];
  logic [PTR_W:0]   w_sum;

  assign w_p   = ({1'b0, ptr} < NV) ? ptr : '0;
  assign w_dbl = {req, req};
  assign w_rot = N'(w_dbl >> w_p);

  // Chain from the top so the lowest rotated offset wins.
  assign w_pos[N] = '0;
  for (genvar k = 0; k < N; k++) begin : g_pos
    assign w_pos[k] = w_rot[k] ? PTR_W'(k) : w_pos[k+1];
  end

  assign w_sum = {1'b0, w_p} + {1'b0, w_pos[0]};
  assign win   = (w_sum >= NV) ? PTR_W'(w_sum - NV)
                               : PTR_W'(w_sum);
  assign any   = |req;

endmodule

// File: rtl/umich_rr_select_stage.sv
// Registered round-robin select stage feeding the select cells.
// Captures the winner word and its one-hot CONTROL vector each transfer.
module umich_rr_select_stage
  import umich_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic           clocked_on,
  input  logic           synch_clear,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   grant,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_sel,
  input  logic           out_ready
);

  localparam int PTR_W = ptr_w(N);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N-1);

  state_t           r_state;
  logic [W-1:0]     r_data;
  logic [N-1:0]     r_sel;
  logic [PTR_W-1:0] r_ptr;

  logic [PTR_W-1:0] w_win;
  logic             w_any;
  logic             w_load;
  logic             w_take;
  logic [N-1:0]     w_oh;
  logic [W-1:0]     w_acc [N+1];

  umich_rr_pick #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .win (w_win),
    .any (w_any)
  );

  assign w_oh   = N'(onehot(int'(w_win), N));
  assign w_load = (r_state == EMPTY) | out_ready;
  assign w_take = w_load & w_any & ~synch_clear;
  assign grant  = w_take ? w_oh : '0;

  // AND-OR slice mux keyed by the one-hot winner.
  assign w_acc[0] = '0;
  for (genvar i = 0; i < N; i++) begin : g_mux
    assign w_acc[i+1] = w_acc[i] |
      (data_in[i*W +: W] & {W{w_oh[i]}});
  end

  always_ff @(posedge clocked_on) begin
    if (synch_clear) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_state <= FULL;
        r_data  <= w_acc[N];
        r_sel   <= w_oh;
        r_ptr   <= (w_win == LAST) ? '0 : w_win + 1'b1;
      end else begin
        r_state <= EMPTY;
        r_sel   <= '0;
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_umich_rr_select_stage.sv
// Bench for umich_rr_select_stage: directed scenarios plus random traffic
// compared against a queue-free behavioural arbiter model.
module tb_umich_rr_select_stage;

  localparam int N = 5;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           synch_clear = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   grant;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_sel;
  logic           out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  int           m_valid = 0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] m_sel = '0;
  int           m_ptr = 0;

  umich_rr_select_stage #(.N(N), .W(W)) dut (
    .clocked_on  (clk),
    .synch_clear (synch_clear),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rq, input int p);
    for (int k = 0; k < N; k++) begin
      int idx = (p + k) % N;
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive one cycle, check pre-edge outputs, advance model and DUT.
  task automatic step(input logic clr, input logic [N-1:0] rq,
                      input logic [N*W-1:0] d, input logic rdy);
    int win;
    int load;
    logic [N-1:0] eg;
    @(negedge clk);
    synch_clear = clr;
    req = rq;
    data_in = d;
    out_ready = rdy;
    #1;
    load = (m_valid == 0 || rdy) ? 1 : 0;
    win = pick(rq, m_ptr);
    eg = (!clr && load == 1 && win >= 0) ? N'(1 << win) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("sel", 32'(out_sel), 32'(m_sel));
    if (m_valid != 0) chk("data", 32'(out_data), 32'(m_data));
    @(posedge clk);
    if (clr) begin
      m_valid = 0; m_data = '0; m_sel = '0; m_ptr = 0;
    end else if (load == 1) begin
      if (win >= 0) begin
        m_valid = 1;
        m_data = W'(d >> (win * W));
        m_sel = N'(1 << win);
        m_ptr = (win + 1) % N;
      end else begin
        m_valid = 0;
        m_sel = '0;
      end
    end
    #1;
  endtask

  function automatic logic [N*W-1:0] slot(input int i, input logic [W-1:0] b);
    logic [N*W-1:0] v;
    v = '0;
    v = v | ((N*W)'(b) << (i * W));
    return v;
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    return (N*W)'({$urandom(), $urandom()});
  endfunction

  logic [N-1:0] rot_exp [6] = '{5'b00001, 5'b00010, 5'b00100,
                                5'b01000, 5'b10000, 5'b00001};

  initial begin
    // Reset with all requesting: no grant, empty output.
    step(1'b1, 5'b11111, rnd_data(), 1'b1);
    step(1'b1, 5'b11111, rnd_data(), 1'b1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'b11111, rnd_data(), 1'b1);
      chk("rot_sel", 32'(out_sel), 32'(rot_exp[i]));
    end

    step(1'b0, 5'b11111, rnd_data(), 1'b1);
    step(1'b0, 5'b11111, rnd_data(), 1'b1);
    chk("bp_sel0", 32'(out_sel), 32'h04);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'b11111, rnd_data(), 1'b0);
      chk("bp_hold", 32'(out_sel), 32'h04);
    end
    step(1'b0, 5'b11111, rnd_data(), 1'b1);
    chk("bp_rel", 32'(out_sel), 32'h08);

    step(1'b0, 5'b00010, rnd_data(), 1'b1);
    chk("sparse1", 32'(out_sel), 32'h02);
    step(1'b0, 5'b10001, rnd_data(), 1'b1);
    chk("sparse4", 32'(out_sel), 32'h10);
    step(1'b0, 5'b00011, rnd_data(), 1'b1);
    chk("wrap0", 32'(out_sel), 32'h01);

    step(1'b0, 5'b01000, slot(3, 8'hA5), 1'b1);
    chk("simul_v", 32'(out_valid), 32'd1);
    chk("simul_d", 32'(out_data), 32'hA5);

    step(1'b0, 5'b00001, slot(0, 8'h3C), 1'b1);
    chk("pre_clr", 32'(out_data), 32'h3C);
    step(1'b1, 5'b11111, rnd_data(), 1'b0);
    chk("clr_v", 32'(out_valid), 32'd0);
    chk("clr_d", 32'(out_data), 32'd0);
    step(1'b0, 5'b11111, rnd_data(), 1'b1);
    chk("clr_ptr", 32'(out_sel), 32'h01);

    step(1'b0, 5'b00000, rnd_data(), 1'b1);
    chk("drain_v", 32'(out_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           N'($urandom()), rnd_data(),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    step(1'b0, 5'b00000, rnd_data(), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
